memory_controller: RTL and testbench
====================================

# memory_controller

Main-memory controller for the PDP-8 simulator: 4096 words × 12 bits with a per-word valid bit, serving one CPU request at a time over the `memory_pins` interface. It accepts single-cycle read or write requests, performs them through a small state machine, and signals completion with a one-cycle `mem_finished` pulse. It sits between the CPU core and the memory array. It also tags reads as instruction fetch or data read for the simulation trace.

## Interface
- Parameters:
  - ADDR_WIDTH, 12, word-address width (4096 words).
  - DATA_WIDTH, 12, word width.
- Ports:
  - clk  input  1  system clock, all state on rising edge.
  - rst_n  input  1  reset: asynchronous and active-low.
  - read_type  input  1  0 = INSTRUCTION_FETCH, 1 = DATA_READ; sampled with read_enable; trace/statistics only, no effect on returned data.
  - pins  memory_pins.slave  —  bundle; all signals as seen by the controller:
    - address  input  12  word address.
    - write_data  input  12  data to store.
    - write_enable  input  1  write request.
    - read_enable  input  1  read request.
    - read_data  output  12  data returned by a read.
    - mem_finished  output  1  one-cycle completion pulse.

## Operation
- Storage:
  - mem[0:4095] of 12 bits.
  - valid[0:4095] of 1 bit, all cleared by reset.
- States are IDLE, ACCESS and DONE.
- IDLE:
  - On a rising edge with write_enable=1, latch address and write_data, record op=WRITE, and go to ACCESS.
  - Otherwise, with read_enable=1, latch address and read_type, record op=READ, and go to ACCESS.
  - If both enables are high, the write wins and the read is dropped.
- ACCESS:
  - WRITE: mem[addr] ← data and valid[addr] ← 1.
  - READ: read_data ← valid[addr] ? mem[addr] : 12'o0000.
  - Go to DONE.
- DONE: mem_finished=1 for this cycle only; return to IDLE.
- Enables seen in ACCESS or DONE are ignored and are not queued.
- read_data holds its last value until the next read completes; writes do not change it.
- Addresses are always in range: 12-bit address, full 4096-word array, no wrap logic needed.
- Simulation-only hooks (under `SIMULATION`), free of synthesis side effects:
  - On each completed read, emit a trace record: type (fetch or data), octal address, octal data.
  - Provide a dump of all valid locations.

## Timing
- Reset (rst_n=0, asynchronous):
  - state=IDLE, mem_finished=0, read_data=12'o0000, all valid bits=0.
  - mem contents are don't-care.
- Latency: a request sampled at edge N → ACCESS at N+1 → mem_finished high from edge N+2 to edge N+3.
- read_data is valid no later than the rising edge of mem_finished and stays stable while it is high.
- Requesters hold an enable for exactly one cycle; an enable held longer starts a new request only once the controller is back in IDLE (edge N+3).
- Minimum request spacing: 3 cycles; a bench issuing one request every 4 cycles never overlaps.
- Reset mid-operation aborts the request:
  - no mem_finished is produced.
  - a write in flight before the ACCESS edge is lost.

## Test plan
- Write 12'o0333 to 12'o0200, then read 12'o0200 → mem_finished pulses 2 cycles after each request; read_data=12'o0333.
- Read 12'o0201, never written → read_data=12'o0000, mem_finished pulses normally.
- Exhaustive sweep: for a = 0..12'o7777, write data=a to address a, then read it → every read returns a; no mismatch across all 4096 words.
- Assert write_enable and read_enable together (address 12'o0100, data 12'o1234) → write performed, exactly one mem_finished; a later read of 12'o0100 returns 12'o1234.
- Issue read_enable during ACCESS or DONE of a prior request → ignored; exactly one mem_finished per accepted request.
- Assert rst_n=0 after writing 12'o0200 → outputs go to 0 immediately; a following read of 12'o0200 returns 12'o0000 (valid bit cleared).

Source files
------------

// File: rtl/memory_controller_if.sv
// Request/response bundle between the CPU core and the main-memory controller.
interface memory_pins #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12
);
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  write_enable;
  logic                  read_enable;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  mem_finished;

  modport master (
    output address, write_data, write_enable, read_enable,
    input  read_data, mem_finished
  );

  modport slave (
    input  address, write_data, write_enable, read_enable,
    output read_data, mem_finished
  );
endinterface

// File: rtl/memory_controller.sv
// PDP-8 main memory: 4096 x 12-bit words with per-word valid bits,
// one request at a time through IDLE -> ACCESS -> DONE.
module memory_controller #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        read_type,
  memory_pins.slave   pins
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  state_t                r_state;
  state_t                w_state_nxt;
  op_t                   r_op;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_read_type;
  logic [DATA_WIDTH-1:0] r_read_data;
  logic                  r_mem_finished;
  logic [DEPTH-1:0]      r_valid;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic w_accept_wr;
  logic w_accept_rd;
  logic w_do_write;
  logic w_do_read;
  logic w_finished_nxt;
  logic w_unused_read_type;

  // Request acceptance: only in IDLE, write has priority over read.
  always_comb begin
    w_accept_wr = 1'b0;
    w_accept_rd = 1'b0;
    if (r_state == S_IDLE) begin
      w_accept_wr = pins.write_enable;
      w_accept_rd = pins.read_enable & ~pins.write_enable;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; enables outside IDLE are ignored, never queued.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept_wr || w_accept_rd) w_state_nxt = S_ACCESS;
      S_ACCESS: w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode: array strobes in ACCESS, completion flag from DONE.
  always_comb begin
    w_do_write     = 1'b0;
    w_do_read      = 1'b0;
    w_finished_nxt = 1'b0;
    case (r_state)
      S_ACCESS: begin
        w_do_write = (r_op == OP_WRITE);
        w_do_read  = (r_op == OP_READ);
      end
      S_DONE:   w_finished_nxt = 1'b1;
      default:  ;
    endcase
  end

  // Request capture; a read leaves the write-data latch untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op        <= OP_READ;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_read_type <= 1'b0;
    end else if (w_accept_wr) begin
      r_op    <= OP_WRITE;
      r_addr  <= pins.address;
      r_wdata <= pins.write_data;
    end else if (w_accept_rd) begin
      r_op        <= OP_READ;
      r_addr      <= pins.address;
      r_read_type <= read_type;
    end
  end

  // Valid bits: cleared by reset, set by each completed write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_valid <= '0;
    else if (w_do_write) r_valid[r_addr] <= 1'b1;
  end

  // Storage array; contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (w_do_write) r_mem[r_addr] <= r_wdata;
  end

  // Read data register: updated only by reads, unwritten words read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_read_data <= '0;
    else if (w_do_read) r_read_data <= r_valid[r_addr] ? r_mem[r_addr] : '0;
  end

  // Completion pulse registered from DONE so it lands two edges after the request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_mem_finished <= 1'b0;
    else        r_mem_finished <= w_finished_nxt;
  end

  assign pins.read_data    = r_read_data;
  assign pins.mem_finished = r_mem_finished;

  // Fetch/data tag only feeds the simulation trace.
  assign w_unused_read_type = r_read_type;

`ifdef SIMULATION
  // Trace record for each read as its data becomes visible.
  always_ff @(posedge clk) begin
    if (rst_n && r_state == S_DONE && r_op == OP_READ)
      $display("MEMTRACE %s addr=%04o data=%04o",
               r_read_type ? "DATA " : "FETCH", r_addr, r_read_data);
  end

  task automatic dump_valid();
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (r_valid[i]) $display("MEMDUMP %04o: %04o", i[ADDR_WIDTH-1:0], r_mem[i]);
    end
  endtask
`endif

endmodule

// File: tb/tb_memory_controller.sv
// Directed self-checking bench for memory_controller.
module tb_memory_controller;

  logic clk;
  logic rst_n;
  logic read_type;

  int n_checks;
  int n_fail;

  memory_pins #(.ADDR_WIDTH(12), .DATA_WIDTH(12)) pins_if ();

  memory_controller #(.ADDR_WIDTH(12), .DATA_WIDTH(12)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .read_type (read_type),
    .pins      (pins_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  // One request: driven at a negedge, sampled at edge N, enables dropped
  // afterwards; watches edges N+1..N+4 for completion pulses.
  task automatic run_req(input logic we, input logic re, input logic [11:0] addr,
                         input logic [11:0] data, input logic rt,
                         output logic [11:0] rd, output int nfin, output int first);
    @(negedge clk);
    pins_if.write_enable = we;
    pins_if.read_enable  = re;
    pins_if.address      = addr;
    pins_if.write_data   = data;
    read_type            = rt;
    @(posedge clk);
    @(negedge clk);
    pins_if.write_enable = 1'b0;
    pins_if.read_enable  = 1'b0;
    nfin  = 0;
    first = -1;
    rd    = 'x;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      #1;
      if (pins_if.mem_finished === 1'b1) begin
        nfin++;
        if (first < 0) first = c;
      end
      if (c == 2) rd = pins_if.read_data;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++;
    if (pins_if.mem_finished !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_finished: got %b expected 0", pins_if.mem_finished);
    end
    n_checks++;
    if (pins_if.read_data !== 12'o0000) begin
      n_fail++;
      $display("FAIL reset_read_data: got %o expected 0000", pins_if.read_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    logic [11:0] rd;
    int nfin, first;
    run_req(1'b1, 1'b0, 12'o0200, 12'o0333, 1'b0, rd, nfin, first);
    n_checks++;
    if (nfin !== 1 || first !== 2) begin
      n_fail++;
      $display("FAIL write_pulse: got count=%0d at=%0d expected count=1 at=2", nfin, first);
    end
    run_req(1'b0, 1'b1, 12'o0200, 12'o0000, 1'b1, rd, nfin, first);
    n_checks++;
    if (nfin !== 1 || first !== 2) begin
      n_fail++;
      $display("FAIL read_pulse: got count=%0d at=%0d expected count=1 at=2", nfin, first);
    end
    n_checks++;
    if (rd !== 12'o0333) begin
      n_fail++;
      $display("FAIL read_0200: got %o expected 0333", rd);
    end
    // A write must leave the last read result in place.
    run_req(1'b1, 1'b0, 12'o0210, 12'o7777, 1'b0, rd, nfin, first);
    n_checks++;
    if (pins_if.read_data !== 12'o0333) begin
      n_fail++;
      $display("FAIL read_data_hold: got %o expected 0333", pins_if.read_data);
    end
  endtask

  task automatic test_unwritten();
    logic [11:0] rd;
    int nfin, first;
    run_req(1'b0, 1'b1, 12'o0201, 12'o0000, 1'b1, rd, nfin, first);
    n_checks++;
    if (rd !== 12'o0000) begin
      n_fail++;
      $display("FAIL unwritten_data: got %o expected 0000", rd);
    end
    n_checks++;
    if (nfin !== 1 || first !== 2) begin
      n_fail++;
      $display("FAIL unwritten_pulse: got count=%0d at=%0d expected count=1 at=2", nfin, first);
    end
  endtask

  task automatic test_both_enables();
    logic [11:0] rd;
    int nfin, first;
    run_req(1'b1, 1'b1, 12'o0100, 12'o1234, 1'b1, rd, nfin, first);
    n_checks++;
    if (nfin !== 1) begin
      n_fail++;
      $display("FAIL both_pulse_count: got %0d expected 1", nfin);
    end
    // The dropped read must not have refreshed read_data (last read gave 0000).
    n_checks++;
    if (rd !== 12'o0000) begin
      n_fail++;
      $display("FAIL both_read_dropped: got %o expected 0000", rd);
    end
    run_req(1'b0, 1'b1, 12'o0100, 12'o0000, 1'b1, rd, nfin, first);
    n_checks++;
    if (rd !== 12'o1234) begin
      n_fail++;
      $display("FAIL both_write_won: got %o expected 1234", rd);
    end
  endtask

  task automatic test_ignore_busy();
    int nfin, first;
    @(negedge clk);
    pins_if.read_enable = 1'b1;
    pins_if.address     = 12'o0100;
    read_type           = 1'b0;
    @(posedge clk);
    @(negedge clk);
    pins_if.address = 12'o0201;
    nfin  = 0;
    first = -1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      #1;
      if (pins_if.mem_finished === 1'b1) begin
        nfin++;
        if (first < 0) first = c;
      end
      // Enable stays high across the ACCESS and DONE edges only.
      if (c == 2) pins_if.read_enable = 1'b0;
      if (c == 2) begin
        n_checks++;
        if (pins_if.read_data !== 12'o1234) begin
          n_fail++;
          $display("FAIL busy_latched_addr: got %o expected 1234", pins_if.read_data);
        end
      end
    end
    n_checks++;
    if (nfin !== 1 || first !== 2) begin
      n_fail++;
      $display("FAIL busy_ignored: got count=%0d at=%0d expected count=1 at=2", nfin, first);
    end
  endtask

  task automatic test_held_enable();
    int nfin, c1, c2;
    @(negedge clk);
    pins_if.read_enable = 1'b1;
    pins_if.address     = 12'o0200;
    @(posedge clk);
    nfin = 0;
    c1 = -1;
    c2 = -1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      if (pins_if.mem_finished === 1'b1) begin
        nfin++;
        if (c1 < 0) c1 = c;
        else if (c2 < 0) c2 = c;
      end
      if (c == 3) pins_if.read_enable = 1'b0;
    end
    n_checks++;
    if (nfin !== 2 || c1 !== 2 || c2 !== 5) begin
      n_fail++;
      $display("FAIL held_enable: got count=%0d at=%0d,%0d expected count=2 at=2,5", nfin, c1, c2);
    end
  endtask

  task automatic test_sweep();
    logic [11:0] rd;
    int nfin, first;
    logic [11:0] a;
    for (int i = 0; i < 4096; i++) begin
      a = i[11:0];
      run_req(1'b1, 1'b0, a, a, 1'b0, rd, nfin, first);
      run_req(1'b0, 1'b1, a, 12'o0000, 1'b1, rd, nfin, first);
      n_checks++;
      if (rd !== a || nfin !== 1) begin
        n_fail++;
        $display("FAIL sweep_%04o: got data=%o count=%0d expected data=%o count=1", a, rd, nfin, a);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] rd;
    int nfin, first;
    run_req(1'b1, 1'b0, 12'o0200, 12'o0333, 1'b0, rd, nfin, first);
    // Start a read and reset while its completion pulse is high.
    @(negedge clk);
    pins_if.read_enable = 1'b1;
    pins_if.address     = 12'o0200;
    @(posedge clk);
    @(negedge clk);
    pins_if.read_enable = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    n_checks++;
    if (pins_if.mem_finished !== 1'b1 || pins_if.read_data !== 12'o0333) begin
      n_fail++;
      $display("FAIL pre_reset_read: got fin=%b data=%o expected fin=1 data=0333",
               pins_if.mem_finished, pins_if.read_data);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (pins_if.mem_finished !== 1'b0 || pins_if.read_data !== 12'o0000) begin
      n_fail++;
      $display("FAIL async_reset: got fin=%b data=%o expected fin=0 data=0000",
               pins_if.mem_finished, pins_if.read_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_req(1'b0, 1'b1, 12'o0200, 12'o0000, 1'b0, rd, nfin, first);
    n_checks++;
    if (rd !== 12'o0000) begin
      n_fail++;
      $display("FAIL valid_cleared: got %o expected 0000", rd);
    end
    // Write aborted by reset before its ACCESS edge.
    @(negedge clk);
    pins_if.write_enable = 1'b1;
    pins_if.address      = 12'o0300;
    pins_if.write_data   = 12'o0555;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    pins_if.write_enable = 1'b0;
    nfin = 0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      #1;
      if (pins_if.mem_finished === 1'b1) nfin++;
      if (c == 1) rst_n = 1'b1;
    end
    n_checks++;
    if (nfin !== 0) begin
      n_fail++;
      $display("FAIL abort_no_pulse: got count=%0d expected 0", nfin);
    end
    run_req(1'b0, 1'b1, 12'o0300, 12'o0000, 1'b1, rd, nfin, first);
    n_checks++;
    if (rd !== 12'o0000) begin
      n_fail++;
      $display("FAIL abort_write_lost: got %o expected 0000", rd);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    read_type = 1'b0;
    pins_if.address      = '0;
    pins_if.write_data   = '0;
    pins_if.write_enable = 1'b0;
    pins_if.read_enable  = 1'b0;
    test_reset();
    test_write_read();
    test_unwritten();
    test_both_enables();
    test_ignore_busy();
    test_held_enable();
    test_sweep();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
